// File: rtl/imem_dmem_arbiter_if.sv
// Request/response and sram bundle shared by the fetch path, the data-memory stage and the sram.
// master: requesters and sram; slave: the arbiter.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;
  logic              mem_cs;
  logic              mem_oe;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_gnt, if_valid, if_rdata, if_stall,
    input  d_gnt, d_valid, d_rdata, d_stall,
    input  mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_gnt, if_valid, if_rdata, if_stall,
    output d_gnt, d_valid, d_rdata, d_stall,
    output mem_cs, mem_oe, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port sram between instruction fetch and data memory.
// ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests.
module imem_dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic clk,
  input logic rst_n,
  imem_dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ird_q, drd_q;
  logic              we_q, we_d;
  logic              ig_q, ig_d;
  logic              dg_q, dg_d;
  logic              busy, last, done;
  logic              ivld, dvld, store;
  logic              take_d, take_i, d_first;

  assign busy = state_q != IDLE;
  assign last = cnt_q == 4'(MEM_LAT - 1);
  assign done = busy && last;
  assign ivld = (state_q == BUSY_I) && last;
  assign dvld = (state_q == BUSY_D) && last;
  assign store = (state_q == BUSY_D) && we_q;

`ifdef ARB_ROUND_ROBIN_EN
  // set after a data grant: fetch wins the next tie
  logic rr_i_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_i_q <= 1'b1;
    else if (take_d) rr_i_q <= 1'b1;
    else if (take_i) rr_i_q <= 1'b0;
  end
  assign d_first = !rr_i_q;
`else
  assign d_first = 1'b1;
`endif

  // on completion the other requester goes first
  always_comb begin
    take_d = 1'b0;
    take_i = 1'b0;
    if (!busy) begin
      take_d = bus.d_req && (d_first || !bus.if_req);
      take_i = bus.if_req && !take_d;
    end else if (done) begin
      if (state_q == BUSY_D) begin
        take_i = bus.if_req;
        take_d = bus.d_req && !bus.if_req;
      end else begin
        take_d = bus.d_req;
        take_i = bus.if_req && !bus.d_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ig_d    = 1'b0;
    dg_d    = 1'b0;
    if (take_d) begin
      state_d = BUSY_D;
      cnt_d   = '0;
      addr_d  = bus.d_addr;
      we_d    = bus.d_we;
      wdata_d = bus.d_wdata;
      dg_d    = 1'b1;
    end else if (take_i) begin
      state_d = BUSY_I;
      cnt_d   = '0;
      addr_d  = bus.if_addr;
      we_d    = 1'b0;
      ig_d    = 1'b1;
    end else if (done) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '1;
      ig_q    <= 1'b0;
      dg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ig_q    <= ig_d;
      dg_q    <= dg_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ird_q <= '0;
      drd_q <= '0;
    end else begin
      if (ivld) ird_q <= bus.mem_dout;
      if (dvld && !we_q) drd_q <= bus.mem_dout;
    end
  end

  assign bus.mem_cs   = busy;
  assign bus.mem_we   = store;
  assign bus.mem_oe   = busy && !store;
  assign bus.mem_addr = busy ? addr_q : '0;
  assign bus.mem_din  = store ? wdata_q : '1;

  assign bus.if_gnt   = ig_q;
  assign bus.d_gnt    = dg_q;
  assign bus.if_valid = ivld;
  assign bus.d_valid  = dvld;
  assign bus.if_rdata = ivld ? bus.mem_dout : ird_q;
  assign bus.d_rdata  = (dvld && !we_q) ? bus.mem_dout : drd_q;
  assign bus.if_stall = bus.if_req && !ivld;
  assign bus.d_stall  = bus.d_req && !dvld;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: transaction-level model checked every cycle
// plus directed literal checks (MEM_LAT=2 main instance, MEM_LAT=1 side instance).
module tb_imem_dmem_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic pre;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter_if b ();
  imem_dmem_arbiter_if b1 ();

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  // sram behind the main instance: word index = addr[9:2]
  logic [31:0] sram [0:255];
  assign b.mem_dout = (b.mem_cs && b.mem_oe) ? sram[b.mem_addr[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
      sram[4] <= 32'h8C220004;
    end else if (b.mem_cs && b.mem_we) begin
      sram[b.mem_addr[9:2]] <= b.mem_din;
    end
  end

  // read-only memory for the MEM_LAT=1 instance: word n holds 0x11111111*(n+1)
  assign b1.mem_dout = (b1.mem_cs && b1.mem_oe)
    ? 32'h11111111 * (32'(b1.mem_addr[3:2]) + 32'd1) : 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  // transaction model: who owns the sram and how many cycles remain
  int          m_own;
  int          m_left;
  logic [31:0] m_addr, m_wd, m_ird, m_drd;
  logic        m_we, m_new, m_rr_i;
  logic [31:0] ref_mem [0:255];

  function automatic logic req_of(input int who);
    return (who == 1) ? b.if_req : b.d_req;
  endfunction

  initial begin
    int nxt;
    logic fin;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_mem[4] = 32'h8C220004;
    m_own = 0; m_left = 0; m_new = 1'b0; m_ird = 0; m_drd = 0;
    m_addr = 0; m_wd = 0; m_we = 1'b0; m_rr_i = 1'b1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_own = 0; m_left = 0; m_new = 1'b0;
        m_ird = 0; m_drd = 0; m_rr_i = 1'b1;
      end else begin
        fin = (m_own != 0) && (m_left == 1);
        if (fin) begin
          if (m_own == 1) m_ird = ref_mem[m_addr[9:2]];
          else if (m_we) ref_mem[m_addr[9:2]] = m_wd;
          else m_drd = ref_mem[m_addr[9:2]];
        end
        m_new = 1'b0;
        if (m_own == 0 || fin) begin
          nxt = 0;
          if (m_own == 0) begin
            if (b.d_req && b.if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
              nxt = m_rr_i ? 1 : 2;
`else
              nxt = 2;
`endif
            end else if (b.d_req) nxt = 2;
            else if (b.if_req) nxt = 1;
          end else begin
            if (req_of(3 - m_own)) nxt = 3 - m_own;
            else if (req_of(m_own)) nxt = m_own;
          end
          if (nxt == 2) begin
            m_addr = b.d_addr; m_we = b.d_we; m_wd = b.d_wdata; m_rr_i = 1'b1;
          end else if (nxt == 1) begin
            m_addr = b.if_addr; m_we = 1'b0; m_rr_i = 1'b0;
          end
          m_own = nxt;
          m_left = LAT;
          m_new = (nxt != 0);
        end else begin
          m_left = m_left - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic ev_i, ev_d, e_st, e_cs;
    if (rst_n) begin
      ev_i = (m_own == 1) && (m_left == 1);
      ev_d = (m_own == 2) && (m_left == 1);
      e_st = (m_own == 2) && m_we;
      e_cs = m_own != 0;
      chk("cyc mem_cs", 32'(b.mem_cs), 32'(e_cs));
      chk("cyc mem_we", 32'(b.mem_we), 32'(e_st));
      chk("cyc mem_oe", 32'(b.mem_oe), 32'(e_cs && !e_st));
      chk("cyc mem_addr", b.mem_addr, e_cs ? m_addr : 32'h0);
      chk("cyc mem_din", b.mem_din, e_st ? m_wd : 32'hFFFFFFFF);
      chk("cyc if_gnt", 32'(b.if_gnt), 32'(m_new && m_own == 1));
      chk("cyc d_gnt", 32'(b.d_gnt), 32'(m_new && m_own == 2));
      chk("cyc if_valid", 32'(b.if_valid), 32'(ev_i));
      chk("cyc d_valid", 32'(b.d_valid), 32'(ev_d));
      chk("cyc if_stall", 32'(b.if_stall), 32'(b.if_req && !ev_i));
      chk("cyc d_stall", 32'(b.d_stall), 32'(b.d_req && !ev_d));
      chk("cyc if_rdata", b.if_rdata, ev_i ? ref_mem[m_addr[9:2]] : m_ird);
      chk("cyc d_rdata", b.d_rdata, (ev_d && !m_we) ? ref_mem[m_addr[9:2]] : m_drd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pre = 1'b1;
    b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    tick();
    tick();
    chk("rst mem_cs", 32'(b.mem_cs), 32'd0);
    chk("rst mem_oe", 32'(b.mem_oe), 32'd0);
    chk("rst mem_we", 32'(b.mem_we), 32'd0);
    chk("rst mem_addr", b.mem_addr, 32'h0);
    chk("rst mem_din", b.mem_din, 32'hFFFFFFFF);
    chk("rst if_rdata", b.if_rdata, 32'h0);
    chk("rst d_rdata", b.d_rdata, 32'h0);
    chk("rst gnt", 32'({b.if_gnt, b.d_gnt, b.if_valid, b.d_valid}), 32'd0);
    pre = 1'b0; rst_n = 1'b1;
    tick();

    // fetch from 0x10
    b.if_req = 1; b.if_addr = 32'h10;
    #1 chk("t1 stall c0", 32'(b.if_stall), 32'd1);
    tick();
    chk("t1 if_gnt c1", 32'(b.if_gnt), 32'd1);
    chk("t1 if_valid c1", 32'(b.if_valid), 32'd0);
    chk("t1 mem_addr c1", b.mem_addr, 32'h10);
    chk("t1 mem_we c1", 32'(b.mem_we), 32'd0);
    tick();
    chk("t1 if_valid c2", 32'(b.if_valid), 32'd1);
    chk("t1 if_rdata c2", b.if_rdata, 32'h8C220004);
    chk("t1 mem_we c2", 32'(b.mem_we), 32'd0);
    b.if_req = 0;
    tick();
    chk("t1 idle cs", 32'(b.mem_cs), 32'd0);
    chk("t1 rdata hold", b.if_rdata, 32'h8C220004);

    // store DEADBEEF to 0x40, inputs scrambled mid-access
    b.d_req = 1; b.d_we = 1; b.d_addr = 32'h40; b.d_wdata = 32'hDEADBEEF;
    tick();
    chk("t2 d_gnt c1", 32'(b.d_gnt), 32'd1);
    chk("t2 mem_we c1", 32'(b.mem_we), 32'd1);
    chk("t2 mem_din c1", b.mem_din, 32'hDEADBEEF);
    chk("t2 mem_addr c1", b.mem_addr, 32'h40);
    b.d_wdata = 32'h0; b.d_addr = 32'h99;
    tick();
    chk("t2 mem_we c2", 32'(b.mem_we), 32'd1);
    chk("t2 mem_din c2", b.mem_din, 32'hDEADBEEF);
    chk("t2 d_valid c2", 32'(b.d_valid), 32'd1);
    chk("t2 d_rdata store", b.d_rdata, 32'h0);
    b.d_req = 0;
    tick();
    b.d_req = 1; b.d_we = 0; b.d_addr = 32'h40;
    tick();
    chk("t2 load gnt", 32'(b.d_gnt), 32'd1);
    tick();
    chk("t2 load valid", 32'(b.d_valid), 32'd1);
    chk("t2 load rdata", b.d_rdata, 32'hDEADBEEF);
    b.d_req = 0;
    tick();

`ifndef ARB_ROUND_ROBIN_EN
    // simultaneous requests: data first, fetch follows without a bubble
    b.if_req = 1; b.if_addr = 32'h10;
    b.d_req = 1; b.d_we = 0; b.d_addr = 32'h40;
    #1 chk("t3 if_stall c0", 32'(b.if_stall), 32'd1);
    tick();
    chk("t3 d_gnt c1", 32'(b.d_gnt), 32'd1);
    chk("t3 if_gnt c1", 32'(b.if_gnt), 32'd0);
    chk("t3 if_stall c1", 32'(b.if_stall), 32'd1);
    tick();
    chk("t3 d_valid c2", 32'(b.d_valid), 32'd1);
    chk("t3 d_rdata c2", b.d_rdata, 32'hDEADBEEF);
    chk("t3 if_stall c2", 32'(b.if_stall), 32'd1);
    b.d_req = 0;
    tick();
    chk("t3 if_gnt c3", 32'(b.if_gnt), 32'd1);
    chk("t3 if_stall c3", 32'(b.if_stall), 32'd1);
    tick();
    chk("t3 if_valid c4", 32'(b.if_valid), 32'd1);
    chk("t3 if_rdata c4", b.if_rdata, 32'h8C220004);
    chk("t3 if_stall c4", 32'(b.if_stall), 32'd0);
    b.if_req = 0;
    tick();
`else
    // continuous requests alternate F, D, F, D with no idle cycle
    b.if_req = 1; b.if_addr = 32'h10;
    b.d_req = 1; b.d_we = 0; b.d_addr = 32'h40;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("rr if_gnt", 32'(b.if_gnt), 32'((k % 2 == 0) && ((k / 2) % 2 == 0)));
      chk("rr d_gnt", 32'(b.d_gnt), 32'((k % 2 == 0) && ((k / 2) % 2 == 1)));
      chk("rr cs", 32'(b.mem_cs), 32'd1);
    end
    b.if_req = 0; b.d_req = 0;
    tick();
`endif

    // reset during the first cycle of a store
    b.d_req = 1; b.d_we = 1; b.d_addr = 32'h80; b.d_wdata = 32'h12345678;
    tick();
    chk("t4 mem_we c1", 32'(b.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4 async cs", 32'(b.mem_cs), 32'd0);
    chk("t4 async we", 32'(b.mem_we), 32'd0);
    chk("t4 async valid", 32'(b.d_valid), 32'd0);
    tick();
    chk("t4 held cs", 32'(b.mem_cs), 32'd0);
    chk("t4 held valid", 32'(b.d_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t4 regrant", 32'(b.d_gnt), 32'd1);
    chk("t4 regrant we", 32'(b.mem_we), 32'd1);
    tick();
    chk("t4 done valid", 32'(b.d_valid), 32'd1);
    b.d_req = 0;
    tick();

    // MEM_LAT=1: back-to-back fetches 0x0, 0x4, 0x8
    b1.if_req = 1; b1.if_addr = 32'h0;
    tick();
    chk("t5 gnt c1", 32'(b1.if_gnt), 32'd1);
    chk("t5 valid c1", 32'(b1.if_valid), 32'd1);
    chk("t5 rdata c1", b1.if_rdata, 32'h11111111);
    b1.if_addr = 32'h4;
    tick();
    chk("t5 valid c2", 32'(b1.if_valid), 32'd1);
    chk("t5 rdata c2", b1.if_rdata, 32'h22222222);
    b1.if_addr = 32'h8;
    tick();
    chk("t5 valid c3", 32'(b1.if_valid), 32'd1);
    chk("t5 rdata c3", b1.if_rdata, 32'h33333333);
    b1.if_req = 0;
    tick();
    chk("t5 valid c4", 32'(b1.if_valid), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
